// File: rtl/fixed_point_pkg.sv
// Shared Q16.16 types, constants and the MAC feeder state encoding.
package fixed_point_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int FRACTION_BITS = 16;

    typedef logic signed [DATA_WIDTH-1:0] q16_16_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_CAPTURE,
        ST_DONE
    } feeder_state_t;

    localparam q16_16_t Q_ONE  = 32'sh0001_0000;
    localparam q16_16_t Q_HALF = 32'sh0000_8000;

endpackage

// File: rtl/fixed_point_pair_fifo.sv
// Synchronous FIFO of {a,b} operand pairs; no fall-through, pop data is the head entry.
module fixed_point_pair_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_a,
    input  logic [DATA_WIDTH-1:0] push_b,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_a,
    output logic [DATA_WIDTH-1:0] pop_b,
    output logic                  full,
    output logic                  empty
);
    import fixed_point_pkg::*;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end

    logic [2*DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [2*DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [AW:0]             wr_ptr_q, wr_ptr_d;
    logic [AW:0]             rd_ptr_q, rd_ptr_d;
    logic                    push_en;
    logic                    pop_en;

    // The extra pointer bit separates full from empty when the indices match.
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign {pop_a, pop_b} = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_en) begin
            mem_d[wr_ptr_q[AW-1:0]] = {push_a, push_b};
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fixed_point_mac_feeder.sv
// Sequencer that clears the MAC, streams vec_len buffered operand pairs into it
// and returns the captured accumulator on a valid/ready result port.
module fixed_point_mac_feeder #(
    parameter int DATA_WIDTH    = 32,
    parameter int FRACTION_BITS = 16,
    parameter int LEN_WIDTH     = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  vec_len,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  mac_clr,
    output logic [DATA_WIDTH-1:0] mac_a,
    output logic [DATA_WIDTH-1:0] mac_b,
    input  logic [DATA_WIDTH-1:0] mac_acc,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data
);
    import fixed_point_pkg::*;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    if (FRACTION_BITS >= DATA_WIDTH) begin : g_bad_frac
        $error("FRACTION_BITS must be smaller than DATA_WIDTH");
    end

    feeder_state_t         state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  count_q, count_d;
    logic                  mac_clr_q, mac_clr_d;
    logic [DATA_WIDTH-1:0] mac_a_q, mac_a_d;
    logic [DATA_WIDTH-1:0] mac_b_q, mac_b_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic                  res_valid_q, res_valid_d;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_a;
    logic [DATA_WIDTH-1:0] fifo_b;

    fixed_point_pair_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (in_valid && in_ready),
        .push_a (in_a),
        .push_b (in_b),
        .pop    (fifo_pop),
        .pop_a  (fifo_a),
        .pop_b  (fifo_b),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign in_ready  = !fifo_full;
    assign busy      = (state_q != ST_IDLE);
    assign mac_clr   = mac_clr_q;
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

    // Operands default to zero so every non-pop cycle feeds the MAC a null product.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        count_d     = count_q;
        mac_clr_d   = 1'b0;
        mac_a_d     = '0;
        mac_b_d     = '0;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        fifo_pop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d     = vec_len;
                    count_d   = '0;
                    mac_clr_d = 1'b1;
                    state_d   = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = (len_q == '0) ? ST_DRAIN : ST_RUN;
            end
            ST_RUN: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    mac_a_d  = fifo_a;
                    mac_b_d  = fifo_b;
                    count_d  = count_q + LEN_ONE;
                    if (count_q + LEN_ONE == len_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                res_data_d  = mac_acc;
                res_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // mac_clr resets high so the MAC stays cleared for the whole reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            count_q     <= '0;
            mac_clr_q   <= 1'b1;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            count_q     <= count_d;
            mac_clr_q   <= mac_clr_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
        end
    end

endmodule

// File: tb/tb_fixed_point_mac_feeder.sv
// Bench for fixed_point_mac_feeder: a behavioural Q16.16 MAC drives mac_acc, and a
// scoreboard predicts each dot product from the pairs and lengths the bench issued.
module tb_fixed_point_mac_feeder;
  import fixed_point_pkg::*;

  localparam int DW = 32;
  localparam int LW = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic [LW-1:0] vec_len;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          mac_clr;
  logic [DW-1:0] mac_a;
  logic [DW-1:0] mac_b;
  logic [DW-1:0] mac_acc;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;

  fixed_point_mac_feeder #(
    .DATA_WIDTH    (DW),
    .FRACTION_BITS (FRACTION_BITS),
    .LEN_WIDTH     (LW),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .vec_len   (vec_len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mac_clr   (mac_clr),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_acc   (mac_acc),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 time units");
    $fatal(1, "watchdog expired");
  end

  // ---------------- MAC model and scoreboard ----------------
  function automatic logic [DW-1:0] q_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return DW'(p >>> FRACTION_BITS);
  endfunction

  always @(posedge clk) begin
    if (mac_clr) mac_acc <= '0;
    else         mac_acc <= mac_acc + q_mul(mac_a, mac_b);
  end

  int            n_cmp = 0;
  int            n_fail = 0;
  logic [DW-1:0] pair_a_q[$];
  logic [DW-1:0] pair_b_q[$];
  int            len_model[$];
  logic [DW-1:0] exp_q[$];
  int            start_cyc = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  logic          hold_valid = 1'b0;
  logic [DW-1:0] hold_data  = '0;

  always @(negedge clk) begin
    if (rst) begin
      hold_valid = 1'b0;
    end else begin
      if (hold_valid) begin
        checkb("res_valid_hold", res_valid, 1'b1);
        check("res_data_hold", res_data, hold_data);
      end
      if (!busy) begin
        check("idle_mac_a", mac_a, '0);
        check("idle_mac_b", mac_b, '0);
        checkb("idle_res_valid", res_valid, 1'b0);
      end
      if (res_valid && res_ready) begin
        if (len_model.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL res_unexpected: got result 0x%08h, want no result", res_data);
        end else begin
          int            n;
          logic [DW-1:0] acc;
          logic [DW-1:0] a;
          logic [DW-1:0] b;
          n = len_model.pop_front();
          if (pair_a_q.size() < n) begin
            n_cmp++;
            n_fail++;
            $display("FAIL res_pairs: got %0d pairs queued, want %0d", pair_a_q.size(), n);
          end else begin
            acc = '0;
            for (int i = 0; i < n; i++) begin
              a = pair_a_q.pop_front();
              b = pair_b_q.pop_front();
              acc = acc + q_mul(a, b);
            end
            exp_q.push_back(acc);
            check("res_data_model", res_data, exp_q.pop_front());
          end
        end
      end
      hold_valid = res_valid && !res_ready;
      hold_data  = res_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    checkb("push_in_ready", in_ready, 1'b1);
    if (in_ready) begin
      pair_a_q.push_back(a);
      pair_b_q.push_back(b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_start(input int len);
    logic accepted;
    start   = 1'b1;
    vec_len = LW'(len);
    @(negedge clk);
    accepted = !busy;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (accepted) begin
      len_model.push_back(len);
      start_cyc = cyc;
    end
  endtask

  task automatic wait_result(input string name, input int exp_lat, input logic [DW-1:0] exp_data);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!res_valid && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    if (!res_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no res_valid in 30 cycles, want latency %0d", name, exp_lat);
    end else begin
      check({name, "_latency"}, DW'(cyc - start_cyc), DW'(exp_lat));
      check({name, "_data"}, res_data, exp_data);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; vec_len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; res_ready = 1'b1;

    // Reset values
    tick(3);
    @(negedge clk);
    checkb("rst_mac_clr", mac_clr, 1'b1);
    checkb("rst_res_valid", res_valid, 1'b0);
    checkb("rst_busy", busy, 1'b0);
    checkb("rst_in_ready", in_ready, 1'b1);
    check("rst_mac_a", mac_a, '0);
    check("rst_res_data", res_data, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(1);
    @(negedge clk);
    checkb("rel_mac_clr", mac_clr, 1'b0);
    @(posedge clk); #1;

    // Single pair: 1.5 * 2.0 = 3.0
    push_pair(32'h0001_8000, 32'h0002_0000);
    do_start(1);
    @(negedge clk);
    checkb("clr_pulse_hi", mac_clr, 1'b1);
    checkb("clr_busy", busy, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    checkb("clr_pulse_lo", mac_clr, 1'b0);
    @(posedge clk); #1;
    wait_result("single", 4, 32'h0003_0000);

    // Two pairs with one bubble: 3.0 + 0.25 = 3.25
    do_start(2);
    push_pair(32'h0001_8000, 32'h0002_0000);
    tick(1);
    push_pair(Q_HALF, Q_HALF);
    wait_result("bubble", 6, 32'h0003_4000);

    // Backpressure, held result, back-to-back vectors
    push_pair(Q_ONE, 32'h0003_0000);
    push_pair(Q_HALF, 32'h0004_0000);
    push_pair(32'hFFFF_0000, 32'h0002_0000);
    push_pair(32'h0002_4000, 32'h0002_0000);
    @(negedge clk);
    checkb("full_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    res_ready = 1'b0;
    do_start(2);
    wait_result("vec_a", 5, 32'h0005_0000);
    @(negedge clk);
    checkb("drained_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    repeat (5) do_start(3);
    @(negedge clk);
    checkb("done_still_valid", res_valid, 1'b1);
    check("done_still_data", res_data, 32'h0005_0000);
    @(posedge clk); #1;
    res_ready = 1'b1;
    tick(1);
    do_start(2);
    wait_result("vec_b", 5, 32'h0002_8000);

    // Zero length leaves the queued pair for the next vector
    push_pair(32'h0002_0000, 32'h0002_0000);
    do_start(0);
    wait_result("zero_len", 3, 32'h0000_0000);
    do_start(1);
    wait_result("after_zero", 4, 32'h0004_0000);

    // Reset in the middle of a starved RUN
    push_pair(Q_ONE, Q_ONE);
    do_start(3);
    tick(4);
    rst = 1'b1;
    tick(1);
    repeat (2) begin
      @(negedge clk);
      checkb("mid_rst_mac_clr", mac_clr, 1'b1);
      checkb("mid_rst_res_valid", res_valid, 1'b0);
      checkb("mid_rst_in_ready", in_ready, 1'b1);
      checkb("mid_rst_busy", busy, 1'b0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    pair_a_q.delete();
    pair_b_q.delete();
    len_model.delete();
    exp_q.delete();
    tick(1);
    @(negedge clk);
    checkb("mid_rel_mac_clr", mac_clr, 1'b0);
    @(posedge clk); #1;
    tick(12);
    @(negedge clk);
    checkb("mid_rel_no_result", res_valid, 1'b0);
    check("pending_vectors", DW'(len_model.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
